// File: rtl/window_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl_pkg
// Shared definitions for the frame raster-read controller: default frame
// geometry, the scan state encoding and a small state decode helper.
// -----------------------------------------------------------------------------
package window_scan_ctrl_pkg;

    // Default frame geometry (pixels per row, rows per frame).
    localparam int DEF_IMG_W = 8;
    localparam int DEF_IMG_H = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    // The controller is busy while reads are issued or the last one is landing.
    function automatic logic is_busy(input scan_state_e s);
        return (s == ST_READ) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/window_scan_ctrl_raster_pos_counter.sv
// -----------------------------------------------------------------------------
// raster_pos_counter
// Column/row position of the pixel currently delivered to the window.
// Column wraps IMG_W-1 -> 0 and the row increments on that wrap.
//   CLK      in   clock, rising edge
//   rst_n    in   synchronous reset, active-low
//   clear    in   restart at (0,0) (frame start)
//   advance  in   step to the next raster position
//   row      out  current row
//   col      out  current column
// -----------------------------------------------------------------------------
module raster_pos_counter #(
    parameter int IMG_W = 8,
    parameter int COL_W = 8,
    parameter int ROW_W = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals; no latches.
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl
// Sequences the raster read of one frame from external image memory into the
// 3x3 window datapath and flags cycles on which the window holds a complete
// neighbourhood (centre at pix_row-1, pix_col-1).
//   CLK        in   clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   start      in   frame request, sampled only in IDLE
//   pause      in   stalls issuing of new reads while high
//   ena        out  memory read enable
//   addr       out  memory read address
//   pix_valid  out  memory data valid (fixed 1-cycle read latency)
//   pix_row    out  row of the pixel qualified by pix_valid
//   pix_col    out  column of the pixel qualified by pix_valid
//   win_valid  out  window holds a full 3x3 neighbourhood
//   busy       out  high in READ or DRAIN
//   done       out  one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module window_scan_ctrl
    import window_scan_ctrl_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 16,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    output logic              ena,
    output logic [ADDR_W-1:0] addr,
    output logic              pix_valid,
    output logic [ROW_W-1:0]  pix_row,
    output logic [COL_W-1:0]  pix_col,
    output logic              win_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pix_valid_q, busy_q, done_q;
    logic              frame_start;

    // pause must gate the read in the same cycle, so ena is decoded from the
    // registered state rather than registered itself.
    assign ena         = (state_q == ST_READ) && !pause;
    assign frame_start = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (ena) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pix_valid_q <= ena;
            busy_q      <= is_busy(state_d);
            done_q      <= (state_d == ST_DONE);
        end
    end

    raster_pos_counter #(
        .IMG_W (IMG_W),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .clear   (frame_start),
        .advance (pix_valid_q),
        .row     (pix_row),
        .col     (pix_col)
    );

    assign addr      = addr_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Border pixels never complete a neighbourhood.
    assign win_valid = pix_valid_q && (pix_row >= ROW_W'(2)) && (pix_col >= COL_W'(2));

endmodule

// File: tb/tb_window_scan_ctrl.sv
module tb_window_scan_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic        CLK = 1'b0;
    logic        rst_n, start, pause;
    logic        ena, pix_valid, win_valid, busy, done;
    logic [15:0] addr;
    logic [7:0]  pix_row, pix_col;

    window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .COL_W(8), .ROW_W(8)) dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .pause(pause),
        .ena(ena), .addr(addr), .pix_valid(pix_valid), .pix_row(pix_row),
        .pix_col(pix_col), .win_valid(win_valid), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is "reads issued so far" plus "pixels landed
    // so far"; positions are plain div/mod of the landed count.
    bit m_in_frame, m_pending, m_done, m_e, chk_en;
    int m_issued, m_delivered;

    function automatic bit m_ena();
        return m_in_frame && (m_issued < N) && !pause;
    endfunction

    always @(posedge CLK) begin
        if (!rst_n) begin
            m_in_frame = 0; m_pending = 0; m_done = 0; m_issued = 0; m_delivered = 0;
        end else begin
            m_e = m_ena();
            if (m_pending) m_delivered++;
            m_pending = m_e;
            if (m_done) m_done = 0;
            else if (m_in_frame) begin
                if (m_issued == N) begin
                    m_in_frame = 0;
                    m_done     = 1;
                end else if (m_e) m_issued++;
            end else if (start) begin
                m_in_frame = 1; m_issued = 0; m_delivered = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            int er, ec;
            er = m_delivered / W;
            ec = m_delivered % W;
            check("ena", ena, m_ena());
            check("addr", addr, m_issued);
            check("pix_valid", pix_valid, m_pending);
            check("pix_row", pix_row, er);
            check("pix_col", pix_col, ec);
            check("win_valid", win_valid, m_pending && er >= 2 && ec >= 2);
            check("busy", busy, m_in_frame);
            check("done", done, m_done);
        end
    end

    // Per-run traces indexed by cycle (cycle c follows the c-1'th edge after
    // the start edge 0).
    bit t_ena [0:127];
    bit t_pv  [0:127];
    bit t_busy[0:127];
    bit t_done[0:127];
    int t_addr[0:127];
    int r_pv, r_win, r_win_first, r_win_row, r_win_col, r_bad_win;
    int r_done_n, r_done_first, r_done_last;

    task automatic run(input int hold_until, input int p_lo, input int p_hi,
                       input int restart_c, input int reset_c, input int max_c);
        r_pv = 0; r_win = 0; r_win_first = -1; r_win_row = -1; r_win_col = -1;
        r_bad_win = 0; r_done_n = 0; r_done_first = -1; r_done_last = -1;
        start = 1'b1;
        for (int c = 1; c <= max_c; c++) begin
            @(posedge CLK); #1;
            start = (c < hold_until) || (c == restart_c);
            pause = (c >= p_lo) && (c <= p_hi);
            rst_n = (c != reset_c);
            @(negedge CLK);
            t_ena[c] = ena; t_pv[c] = pix_valid; t_busy[c] = busy;
            t_done[c] = done; t_addr[c] = int'(addr);
            if (pix_valid) r_pv++;
            if (win_valid) begin
                r_win++;
                if (pix_col < 2) r_bad_win++;
                if (r_win_first < 0) begin
                    r_win_first = c; r_win_row = pix_row; r_win_col = pix_col;
                end
            end
            if (done) begin
                r_done_n++;
                if (r_done_first < 0) r_done_first = c;
                r_done_last = c;
            end
        end
        start = 1'b0; pause = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; chk_en = 0;
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        chk_en = 1;
        @(negedge CLK);
        check("rst_ena", ena, 0);
        check("rst_addr", addr, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // 1/2: plain frame
        run(1, 0, -1, 0, 0, 40);
        check("t1_ena_c1", t_ena[1], 1);
        check("t1_addr_c1", t_addr[1], 0);
        check("t1_addr_c32", t_addr[32], 31);
        check("t1_ena_c33", t_ena[33], 0);
        check("t1_pv_c1", t_pv[1], 0);
        check("t1_pv_c2", t_pv[2], 1);
        check("t1_pv_c33", t_pv[33], 1);
        check("t1_pv_count", r_pv, 32);
        check("t1_done_cycle", r_done_first, 34);
        check("t1_done_count", r_done_n, 1);
        check("t1_busy_c1", t_busy[1], 1);
        check("t1_busy_c33", t_busy[33], 1);
        check("t1_busy_c34", t_busy[34], 0);
        check("t2_win_count", r_win, 12);
        check("t2_win_first_cycle", r_win_first, 20);
        check("t2_win_first_row", r_win_row, 2);
        check("t2_win_first_col", r_win_col, 2);
        check("t2_win_col_lt2", r_bad_win, 0);

        // 3: pause during cycles 5..7
        run(1, 5, 7, 0, 0, 45);
        check("t3_ena_c5", t_ena[5], 0);
        check("t3_ena_c7", t_ena[7], 0);
        check("t3_addr_c6", t_addr[6], 4);
        check("t3_addr_c8", t_addr[8], 4);
        check("t3_ena_c8", t_ena[8], 1);
        check("t3_pv_c5", t_pv[5], 1);
        check("t3_pv_c6", t_pv[6], 0);
        check("t3_done_cycle", r_done_first, 37);
        check("t3_pv_count", r_pv, 32);

        // 4: start while busy is ignored
        run(1, 0, -1, 10, 0, 40);
        check("t4_pv_count", r_pv, 32);
        check("t4_done_count", r_done_n, 1);
        check("t4_done_cycle", r_done_first, 34);

        // 5: reset mid-frame, then a fresh frame
        run(1, 0, -1, 0, 15, 20);
        check("t5_ena_c16", t_ena[16], 0);
        check("t5_addr_c16", t_addr[16], 0);
        check("t5_pv_c16", t_pv[16], 0);
        check("t5_busy_c16", t_busy[16], 0);
        check("t5_no_done", r_done_n, 0);
        check("t5_row_idle", pix_row, 0);
        check("t5_col_idle", pix_col, 0);
        run(1, 0, -1, 0, 0, 40);
        check("t5_new_addr_c1", t_addr[1], 0);
        check("t5_new_ena_c1", t_ena[1], 1);
        check("t5_new_done_cycle", r_done_first, 34);
        check("t5_new_win_count", r_win, 12);

        // 6: start held high -> back-to-back frames
        run(70, 0, -1, 0, 0, 75);
        check("t6_done_count", r_done_n, 2);
        check("t6_done_first", r_done_first, 34);
        check("t6_done_second", r_done_last, 69);
        check("t6_idle_c35", t_busy[35], 0);
        check("t6_busy_c36", t_busy[36], 1);
        check("t6_addr_c36", t_addr[36], 0);
        check("t6_ena_c36", t_ena[36], 1);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK); #1;
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(posedge CLK); #1;
        start = 1'b0; pause = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
